// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared definitions for the round-robin RAM controller.
//   - FSM state encoding (IDLE / ACC / RESP)
//   - transaction direction encoding (write / read)
//   - default word and address widths
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 2;

endpackage

// File: rtl/ram_bank.sv
// ram_bank: 2**AW x DW word store.
//   clk   : system clock
//   clr   : synchronous active-high clear, zeroes every word (wins over we)
//   we    : write enable, word at addr takes wdata at the rising edge
//   addr  : word address
//   wdata : write data
//   rdata : combinational read of the word at addr
module ram_bank
  import ram_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[addr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ram_rr_ctrl.sv
// ram_rr_ctrl: two-requester round-robin arbiter and sequencer in front of
// a ram_bank. Each transaction runs IDLE -> ACC -> RESP -> IDLE.
//   clk, clr                      : clock, synchronous active-high reset
//   req_x, rw_x, addr_x, data_x   : requester x (a/b) level request,
//                                   direction (1 = write), address, write data
//   gnt_x                         : requester x owns the bank (ACC and RESP)
//   done_x                        : one-cycle completion pulse (RESP)
//   o                             : read data during a read's RESP, else 0
//   busy                          : FSM not in IDLE
module ram_rr_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_a,
  input  logic          rw_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          req_b,
  input  logic          rw_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          done_a,
  output logic          done_b,
  output logic [DW-1:0] o,
  output logic          busy
);

  state_t        state_q, state_d;
  logic          own_b_q, own_b_d;     // current owner: 1 = B, 0 = A
  logic          last_b_q, last_b_d;   // last winner:   1 = B, 0 = A
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          win_b;
  logic          bank_we;
  logic [DW-1:0] bank_rdata;

  // B wins when it is the only requester, or on a tie when A won last time.
  assign win_b = req_b & (~req_a | ~last_b_q);

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      own_b_q  <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      own_b_q  <= own_b_d;
      last_b_q <= last_b_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    own_b_d  = own_b_q;
    last_b_d = last_b_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_a | req_b) begin
          state_d  = ST_ACC;
          own_b_d  = win_b;
          last_b_d = win_b;
        end
      end
      ST_ACC:  state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    done_a  = 1'b0;
    done_b  = 1'b0;
    o       = '0;
    busy    = (state_q != ST_IDLE);
    bank_we = 1'b0;
    unique case (state_q)
      ST_ACC: begin
        gnt_a   = ~own_b_q;
        gnt_b   = own_b_q;
        bank_we = (rw_q == RW_WRITE);
      end
      ST_RESP: begin
        gnt_a  = ~own_b_q;
        gnt_b  = own_b_q;
        done_a = ~own_b_q;
        done_b = own_b_q;
        if (rw_q == RW_READ) begin
          o = rdata_q;
        end
      end
      default: ;
    endcase
  end

  // Transaction latch and read capture. These hold data only, so they are
  // not reset; o is forced to 0 outside RESP by the output logic.
  always_comb begin
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if ((state_q == ST_IDLE) && (req_a | req_b)) begin
      rw_d    = win_b ? rw_b   : rw_a;
      addr_d  = win_b ? addr_b : addr_a;
      wdata_d = win_b ? data_b : data_a;
    end
    if (state_q == ST_ACC) begin
      rdata_d = bank_rdata;
    end
  end

  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  // A clr at the end of ACC wins inside the bank, so an in-flight write
  // is dropped and the word reads back as 0.
  ram_bank #(
    .DW (DW),
    .AW (AW)
  ) u_bank (
    .clk   (clk),
    .clr   (clr),
    .we    (bank_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (bank_rdata)
  );

endmodule

// File: tb/tb_ram_rr_ctrl.sv
module tb_ram_rr_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       req_a, rw_a, req_b, rw_b;
  logic [1:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b, done_a, done_b, busy;
  logic [7:0] o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_rr_ctrl #(.DW(8), .AW(2)) dut (
    .clk    (clk),
    .clr    (clr),
    .req_a  (req_a),
    .rw_a   (rw_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .req_b  (req_b),
    .rw_b   (rw_b),
    .addr_b (addr_b),
    .data_b (data_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .done_a (done_a),
    .done_b (done_b),
    .o      (o),
    .busy   (busy)
  );

  // Drives one isolated transaction for requester A (who_b=0) or B (who_b=1)
  // and reports what was observed; the callers do the comparisons.
  task automatic txn(input bit who_b, input bit rw, input logic [1:0] a,
                     input logic [7:0] d, output logic acc_ok,
                     output logic resp_ok, output logic [7:0] resp_o,
                     output logic other_seen);
    @(negedge clk);
    if (!who_b) begin req_a = 1; rw_a = rw; addr_a = a; data_a = d; end
    else        begin req_b = 1; rw_b = rw; addr_b = a; data_b = d; end
    @(posedge clk); #1;
    acc_ok     = who_b ? (gnt_b && !done_b && busy) : (gnt_a && !done_a && busy);
    other_seen = who_b ? (gnt_a | done_a) : (gnt_b | done_b);
    // Scramble the inputs after the latch edge: must have no effect.
    if (!who_b) begin rw_a = ~rw; addr_a = ~a; data_a = ~d; end
    else        begin rw_b = ~rw; addr_b = ~a; data_b = ~d; end
    @(posedge clk); #1;
    resp_ok    = who_b ? (gnt_b && done_b) : (gnt_a && done_a);
    resp_o     = o;
    other_seen = other_seen | (who_b ? (gnt_a | done_a) : (gnt_b | done_b));
    if (!who_b) req_a = 0; else req_b = 0;
    @(posedge clk); #1;
    resp_ok = resp_ok && !busy && !done_a && !done_b && !gnt_a && !gnt_b;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
  endtask

  task automatic test_reset();
    logic acc_ok, resp_ok, other;
    logic [7:0] ro;
    do_clr();
    // Put a nonzero word in the bank, then reset again to see it cleared.
    txn(0, 1, 2'd2, 8'h33, acc_ok, resp_ok, ro, other);
    do_clr();
    checks++;
    if ({busy, gnt_a, gnt_b, done_a, done_b} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/gnt/done=%b expected 00000", {busy, gnt_a, gnt_b, done_a, done_b});
    end
    checks++;
    if (o !== 8'h00) begin
      errors++;
      $display("FAIL reset_o: got %h expected 00", o);
    end
    for (int i = 0; i < 4; i++) begin
      txn(0, 0, 2'(i), 8'h00, acc_ok, resp_ok, ro, other);
      checks++;
      if (!(acc_ok && resp_ok)) begin
        errors++;
        $display("FAIL reset_read_hs[%0d]: acc=%b resp=%b expected 1 1", i, acc_ok, resp_ok);
      end
      checks++;
      if (ro !== 8'h00) begin
        errors++;
        $display("FAIL reset_read_data[%0d]: got %h expected 00", i, ro);
      end
    end
  endtask

  task automatic test_single();
    logic acc_ok, resp_ok, other;
    logic [7:0] ro;
    txn(0, 1, 2'd1, 8'h0C, acc_ok, resp_ok, ro, other);
    checks++;
    if (!(acc_ok && resp_ok) || other || ro !== 8'h00) begin
      errors++;
      $display("FAIL single_write: acc=%b resp=%b gnt_b=%b o=%h expected 1 1 0 00", acc_ok, resp_ok, other, ro);
    end
    txn(0, 0, 2'd1, 8'h00, acc_ok, resp_ok, ro, other);
    checks++;
    if (!(acc_ok && resp_ok) || other) begin
      errors++;
      $display("FAIL single_read_hs: acc=%b resp=%b gnt_b=%b expected 1 1 0", acc_ok, resp_ok, other);
    end
    checks++;
    if (ro !== 8'h0C) begin
      errors++;
      $display("FAIL single_read_data: got %h expected 0c", ro);
    end
  endtask

  // Both requesters hold req for four transactions: ownership alternates
  // A, B, A, B starting with A because reset leaves last_winner = B.
  task automatic test_simultaneous();
    logic [3:0] owner_b;
    logic [7:0] b_reads [2];
    int nb;
    logic exp_b;
    do_clr();
    @(negedge clk);
    req_a = 1; rw_a = 1; addr_a = 2'd2; data_a = 8'hAA;
    req_b = 1; rw_b = 0; addr_b = 2'd2; data_b = 8'h00;
    nb = 0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;                 // ACC
      owner_b[t] = gnt_b;
      exp_b = (t % 2 == 1);
      checks++;
      if ((gnt_a !== ~exp_b) || (gnt_b !== exp_b)) begin
        errors++;
        $display("FAIL tie_order[%0d]: gnt_a=%b gnt_b=%b expected %b %b", t, gnt_a, gnt_b, ~exp_b, exp_b);
      end
      @(posedge clk); #1;                 // RESP
      if (done_b && nb < 2) begin b_reads[nb] = o; nb++; end
      if (t >= 2) begin
        if (exp_b) req_b = 0; else req_a = 0;
      end
      @(posedge clk); #1;                 // IDLE
    end
    checks++;
    if (nb != 2 || b_reads[0] !== 8'hAA || b_reads[1] !== 8'hAA) begin
      errors++;
      $display("FAIL tie_b_read: count=%0d first=%h expected 2 aa", nb, b_reads[0]);
    end
    req_a = 0; req_b = 0;
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    do_clr();
    @(negedge clk);
    req_b = 1; rw_b = 1; addr_b = 2'd3; data_b = 8'h55;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      exp_done = (c == 2 || c == 5 || c == 8);
      checks++;
      if (done_b !== exp_done || gnt_a !== 1'b0) begin
        errors++;
        $display("FAIL b2b_cycle[%0d]: done_b=%b gnt_a=%b expected %b 0", c, done_b, gnt_a, exp_done);
      end
      if (c == 8) begin req_a = 1; rw_a = 0; addr_a = 2'd3; data_a = 8'h00; end
    end
    // Cycle 9 was IDLE with both requesting and last_winner = B.
    @(posedge clk); #1;
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handoff: gnt_a=%b gnt_b=%b expected 1 0", gnt_a, gnt_b);
    end
    req_b = 0;
    @(posedge clk); #1;
    checks++;
    if (done_a !== 1'b1 || o !== 8'h55) begin
      errors++;
      $display("FAIL b2b_a_read: done_a=%b o=%h expected 1 55", done_a, o);
    end
    req_a = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic acc_ok, resp_ok, other;
    logic [7:0] ro;
    @(negedge clk);
    req_a = 1; rw_a = 1; addr_a = 2'd0; data_a = 8'hFF;
    @(posedge clk); #1;                   // ACC
    clr = 1; req_a = 0;
    @(posedge clk); #1;
    clr = 0;
    checks++;
    if ({done_a, gnt_a, busy} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_state: done_a/gnt_a/busy=%b expected 000", {done_a, gnt_a, busy});
    end
    @(posedge clk); #1;
    checks++;
    if (done_a !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_nodone: done_a=%b busy=%b expected 0 0", done_a, busy);
    end
    txn(0, 0, 2'd0, 8'h00, acc_ok, resp_ok, ro, other);
    checks++;
    if (!resp_ok || ro !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_read: resp=%b o=%h expected 1 00", resp_ok, ro);
    end
  endtask

  task automatic test_top_addr();
    logic acc_ok, resp_ok, other;
    logic [7:0] ro;
    txn(1, 1, 2'd3, 8'h81, acc_ok, resp_ok, ro, other);
    checks++;
    if (!(acc_ok && resp_ok) || other) begin
      errors++;
      $display("FAIL top_write_hs: acc=%b resp=%b gnt_a=%b expected 1 1 0", acc_ok, resp_ok, other);
    end
    txn(0, 0, 2'd3, 8'h00, acc_ok, resp_ok, ro, other);
    checks++;
    if (ro !== 8'h81) begin
      errors++;
      $display("FAIL top_read3: got %h expected 81", ro);
    end
    txn(0, 0, 2'd0, 8'h00, acc_ok, resp_ok, ro, other);
    checks++;
    if (ro !== 8'h00) begin
      errors++;
      $display("FAIL top_read0: got %h expected 00", ro);
    end
  endtask

  initial begin
    clr = 0;
    req_a = 0; rw_a = 0; addr_a = '0; data_a = '0;
    req_b = 0; rw_b = 0; addr_b = '0; data_b = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_top_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
